// File: rtl/pipe_scroller.sv
// pipe_scroller: two horizontally scrolling pipe obstacles with LFSR-randomised
// gap heights, a one-tick "pipe passed" pulse and a saturating 3-digit BCD score.
// Build option: define PIPE_SPEEDUP_EN to make the scroll step grow with the
// score (1 px below 10, 2 px from 10, 3 px from 20 upwards). Without it the
// step is the constant 1 and no speed logic is generated.
module pipe_scroller #(
   parameter int          SCREEN_W  = 640,
   parameter int          PIPE_W    = 40,
   parameter int          START1_X  = 319,
   parameter int          START2_X  = 639,
   parameter int          INIT_Y    = 240,
   parameter int          Y_MIN     = 100,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        game_clk,
   input  logic        reset,
   input  logic        restart,
   input  logic        enable,
   input  logic [10:0] bird_x,
   output logic [10:0] pipe1_x,
   output logic [10:0] pipe1_y,
   output logic [10:0] pipe2_x,
   output logic [10:0] pipe2_y,
   output logic        passed,
   output logic [11:0] score
);

   localparam logic [10:0] WRAP_X   = 11'(SCREEN_W - 1);
   localparam logic [11:0] EDGE_OFS = 12'(PIPE_W - 1);

   logic [15:0] lfsr_reg;
   logic [15:0] lfsr_next;
   logic [11:0] score_reg;
   logic [11:0] score_next;
   logic        passed_reg;
   logic [1:0]  step;
   logic [1:0]  hit;
   logic [1:0]  pass_count;
   logic [21:0] x_all;
   logic [21:0] y_all;

   // BCD add of 0..2 with in-cycle digit carry; saturates at 999
   function automatic logic [11:0] bcd_add(input logic [11:0] value, input logic [1:0] amount);
      logic [4:0]  ones;
      logic [4:0]  tens;
      logic [4:0]  hundreds;
      logic [11:0] result;
      ones     = {1'b0, value[3:0]} + {3'b000, amount};
      tens     = {1'b0, value[7:4]};
      hundreds = {1'b0, value[11:8]};
      if (ones > 5'd9) begin
         ones = ones - 5'd10;
         tens = tens + 5'd1;
      end
      if (tens > 5'd9) begin
         tens     = tens - 5'd10;
         hundreds = hundreds + 5'd1;
      end
      if (hundreds > 5'd9)
         result = 12'h999;
      else
         result = {hundreds[3:0], tens[3:0], ones[3:0]};
      return result;
   endfunction

   // Fibonacci LFSR x^16+x^14+x^13+x^11+1, feedback enters bit 0
   always_comb begin
      lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
   end

   // LFSR free-runs through restart and while paused; only reset reseeds it
   always_ff @(posedge game_clk) begin
      if (reset)
         lfsr_reg <= LFSR_SEED;
      else
         lfsr_reg <= lfsr_next;
   end

`ifdef PIPE_SPEEDUP_EN
   // Scroll step taken from the registered score: 1 below 10, 2 in 10..19, else 3
   always_comb begin
      step = 2'd3;
      if (score_reg[11:8] == 4'd0) begin
         if (score_reg[7:4] == 4'd0)
            step = 2'd1;
         else if (score_reg[7:4] == 4'd1)
            step = 2'd2;
      end
   end
`else
   assign step = 2'd1;
`endif

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_pipe
         localparam logic [10:0] START_X = (gi == 0) ? 11'(START1_X) : 11'(START2_X);

         logic [10:0] x_reg;
         logic [10:0] y_reg;
         logic        wrap;
         logic [11:0] right_edge;
         logic [11:0] right_next;

         // Crossing is judged in 12 bits: right edge now vs. right edge after this step
         assign wrap       = x_reg < {9'd0, step};
         assign right_edge = {1'b0, x_reg} + EDGE_OFS;
         assign right_next = right_edge - {10'd0, step};
         assign hit[gi]    = enable && !wrap
                             && (right_edge >= {1'b0, bird_x})
                             && (right_next <  {1'b0, bird_x});

         // Pipe position and gap height; a wrapping pipe draws its own LFSR byte
         always_ff @(posedge game_clk) begin
            if (reset || restart) begin
               x_reg <= START_X;
               y_reg <= 11'(INIT_Y);
            end else if (enable) begin
               if (wrap) begin
                  x_reg <= WRAP_X;
                  y_reg <= 11'(Y_MIN) + {3'd0, lfsr_reg[gi*8 +: 8]};
               end else begin
                  x_reg <= x_reg - {9'd0, step};
               end
            end
         end

         assign x_all[gi*11 +: 11] = x_reg;
         assign y_all[gi*11 +: 11] = y_reg;
      end
   endgenerate

   assign pass_count = {hit[1] & hit[0], hit[1] ^ hit[0]};

   // Score after this tick's passes
   always_comb begin
      score_next = bcd_add(score_reg, pass_count);
   end

   // Pass pulse and score update on the crossing edge; paused game holds the score
   always_ff @(posedge game_clk) begin
      if (reset || restart) begin
         score_reg  <= 12'h000;
         passed_reg <= 1'b0;
      end else begin
         passed_reg <= |hit;
         if (enable)
            score_reg <= score_next;
      end
   end

   assign pipe1_x = x_all[10:0];
   assign pipe2_x = x_all[21:11];
   assign pipe1_y = y_all[10:0];
   assign pipe2_y = y_all[21:11];
   assign passed  = passed_reg;
   assign score   = score_reg;

endmodule

// File: tb/tb_pipe_scroller.sv
// tb_pipe_scroller: table vectors, directed corner sequences and a randomised
// phase, all checked against a behavioural model of the game rules. Two DUTs
// run side by side: the default playfield and a narrow 64-px playfield that
// reaches the score saturation point within a short run.
module tb_pipe_scroller;

   typedef struct {
      bit rst;
      bit rs;
      bit en;
      int p1x;
      int p1y;
      int p2x;
      int p2y;
      int pas;
      int sc;
   } vec_t;

   logic        game_clk = 1'b0;
   logic        reset    = 1'b1;
   logic        restart  = 1'b0;
   logic        enable   = 1'b0;
   logic [10:0] bird_a   = 11'd100;
   logic [10:0] bird_b   = 11'd30;

   logic [10:0] p1x_a, p1y_a, p2x_a, p2y_a;
   logic [10:0] p1x_b, p1y_b, p2x_b, p2y_b;
   logic        passed_a, passed_b;
   logic [11:0] score_a, score_b;

   int n_checks = 0;
   int n_fail   = 0;

   // model configuration per instance (0 = default playfield, 1 = narrow)
   int sw [2]    = '{640, 64};
   int pw [2]    = '{40, 4};
   int sx [2][2] = '{'{319, 639}, '{20, 52}};

   // model state: positions, gap heights, integer score, pulse, LFSR
   int mx [2][2];
   int my [2][2];
   int msc [2];
   bit mpass [2];
   int mlfsr [2];

   always #5 game_clk = ~game_clk;

   pipe_scroller dut_a (
      .game_clk (game_clk),
      .reset    (reset),
      .restart  (restart),
      .enable   (enable),
      .bird_x   (bird_a),
      .pipe1_x  (p1x_a),
      .pipe1_y  (p1y_a),
      .pipe2_x  (p2x_a),
      .pipe2_y  (p2y_a),
      .passed   (passed_a),
      .score    (score_a)
   );

   pipe_scroller #(
      .SCREEN_W (64),
      .PIPE_W   (4),
      .START1_X (20),
      .START2_X (52)
   ) dut_b (
      .game_clk (game_clk),
      .reset    (reset),
      .restart  (restart),
      .enable   (enable),
      .bird_x   (bird_b),
      .pipe1_x  (p1x_b),
      .pipe1_y  (p1y_b),
      .pipe2_x  (p2x_b),
      .pipe2_y  (p2y_b),
      .passed   (passed_b),
      .score    (score_b)
   );

   function automatic int to_bcd(input int s);
      return ((s / 100) << 8) | (((s / 10) % 10) << 4) | (s % 10);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
      end
   endtask

   task automatic model_restore(input int i);
      for (int p = 0; p < 2; p++) begin
         mx[i][p] = sx[i][p];
         my[i][p] = 240;
      end
      msc[i]   = 0;
      mpass[i] = 1'b0;
   endtask

   // one game tick of the rules, applied to model instance i
   task automatic model_step(input int i, input bit rst, input bit rs, input bit en, input int bird);
      int l;
      int st;
      int cnt;
      l = mlfsr[i];
      if (rst) begin
         model_restore(i);
         mlfsr[i] = 'hACE1;
      end else begin
         if (rs) begin
            model_restore(i);
         end else if (en) begin
            st = 1;
`ifdef PIPE_SPEEDUP_EN
            if (msc[i] >= 100)
               st = 3;
            else
               st = 1 + (((msc[i] / 10) % 10) < 2 ? ((msc[i] / 10) % 10) : 2);
`endif
            cnt = 0;
            for (int p = 0; p < 2; p++) begin
               if (mx[i][p] < st) begin
                  mx[i][p] = sw[i] - 1;
                  my[i][p] = 100 + ((l >> (8 * p)) & 255);
               end else begin
                  if ((mx[i][p] + pw[i] - 1 >= bird) && (mx[i][p] - st + pw[i] - 1 < bird))
                     cnt++;
                  mx[i][p] = mx[i][p] - st;
               end
            end
            msc[i]   = (msc[i] + cnt > 999) ? 999 : msc[i] + cnt;
            mpass[i] = (cnt > 0);
         end else begin
            mpass[i] = 1'b0;
         end
         mlfsr[i] = ((l << 1) & 'hFFFF) | (((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1);
      end
   endtask

   task automatic compare_all();
      check("A_p1x", int'(p1x_a), mx[0][0]);
      check("A_p1y", int'(p1y_a), my[0][0]);
      check("A_p2x", int'(p2x_a), mx[0][1]);
      check("A_p2y", int'(p2y_a), my[0][1]);
      check("A_passed", int'(passed_a), int'(mpass[0]));
      check("A_score", int'(score_a), to_bcd(msc[0]));
      check("B_p1x", int'(p1x_b), mx[1][0]);
      check("B_p1y", int'(p1y_b), my[1][0]);
      check("B_p2x", int'(p2x_b), mx[1][1]);
      check("B_p2y", int'(p2y_b), my[1][1]);
      check("B_passed", int'(passed_b), int'(mpass[1]));
      check("B_score", int'(score_b), to_bcd(msc[1]));
   endtask

   // drive one tick, advance the model on the same edge, sample 1 time unit later
   task automatic tick(input bit rst, input bit rs, input bit en);
      reset   = rst;
      restart = rs;
      enable  = en;
      @(posedge game_clk);
      model_step(0, rst, rs, en, int'(bird_a));
      model_step(1, rst, rs, en, int'(bird_b));
      #1;
      compare_all();
   endtask

   initial begin
      vec_t vecs [9];
      int   h1x, h1y, h2x, h2y, hsc;
`ifdef PIPE_SPEEDUP_EN
      int   xprev;
`endif

      //           rst rs en  p1x  p1y  p2x  p2y pas  score
      vecs[0] = '{1'b1, 1'b0, 1'b0, 319, 240, 639, 240, 0, 'h000};
      vecs[1] = '{1'b0, 1'b0, 1'b0, 319, 240, 639, 240, 0, 'h000};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 318, 240, 638, 240, 0, 'h000};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 317, 240, 637, 240, 0, 'h000};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 317, 240, 637, 240, 0, 'h000};
      vecs[5] = '{1'b0, 1'b1, 1'b1, 319, 240, 639, 240, 0, 'h000};
      vecs[6] = '{1'b1, 1'b1, 1'b1, 319, 240, 639, 240, 0, 'h000};
      vecs[7] = '{1'b0, 1'b0, 1'b1, 318, 240, 638, 240, 0, 'h000};
      vecs[8] = '{1'b1, 1'b0, 1'b0, 319, 240, 639, 240, 0, 'h000};

      bird_a = 11'd100;
      bird_b = 11'd30;

      for (int v = 0; v < 9; v++) begin
         tick(vecs[v].rst, vecs[v].rs, vecs[v].en);
         check($sformatf("vec%0d_p1x", v), int'(p1x_a), vecs[v].p1x);
         check($sformatf("vec%0d_p1y", v), int'(p1y_a), vecs[v].p1y);
         check($sformatf("vec%0d_p2x", v), int'(p2x_a), vecs[v].p2x);
         check($sformatf("vec%0d_p2y", v), int'(p2y_a), vecs[v].p2y);
         check($sformatf("vec%0d_passed", v), int'(passed_a), vecs[v].pas);
         check($sformatf("vec%0d_score", v), int'(score_a), vecs[v].sc);
         $display("vec %0d: rst=%0d restart=%0d en=%0d -> p1x=%0d p2x=%0d passed=%0d score=%03h",
                  v, vecs[v].rst, vecs[v].rs, vecs[v].en, p1x_a, p2x_a, passed_a, score_a);
      end

      // scroll up to the crossing with bird_x = 100
      for (int k = 0; k < 258; k++) tick(1'b0, 1'b0, 1'b1);
      check("scroll258_p1x", int'(p1x_a), 61);
      check("scroll258_passed", int'(passed_a), 0);
      $display("scroll: after 258 ticks p1x=%0d passed=%0d", p1x_a, passed_a);
      tick(1'b0, 1'b0, 1'b1);
      check("cross_p1x", int'(p1x_a), 60);
      check("cross_passed", int'(passed_a), 1);
      check("cross_score", int'(score_a), 'h001);
      $display("cross: p1x=%0d passed=%0d score=%03h", p1x_a, passed_a, score_a);
      tick(1'b0, 1'b0, 1'b1);
      check("pulse_end_passed", int'(passed_a), 0);
      check("pulse_end_score", int'(score_a), 'h001);
      $display("pulse end: passed=%0d score=%03h", passed_a, score_a);

      // run pipe1 down to the left border and across the wrap
      for (int k = 0; k < 59; k++) tick(1'b0, 1'b0, 1'b1);
      check("prewrap_p1x", int'(p1x_a), 0);
      tick(1'b0, 1'b0, 1'b1);
      check("wrap_p1x", int'(p1x_a), 639);
      check("wrap_p1y", int'(p1y_a), my[0][0]);
      check("wrap_p1y_range", int'(p1y_a >= 11'd100 && p1y_a <= 11'd355), 1);
      check("wrap_p2x", int'(p2x_a), 319);
      check("wrap_p2y", int'(p2y_a), 240);
      $display("wrap: p1x=%0d p1y=%0d p2x=%0d p2y=%0d", p1x_a, p1y_a, p2x_a, p2y_a);

      // pause for 50 ticks
      h1x = int'(p1x_a); h1y = int'(p1y_a); h2x = int'(p2x_a); h2y = int'(p2y_a); hsc = int'(score_a);
      for (int k = 0; k < 50; k++) tick(1'b0, 1'b0, 1'b0);
      check("hold_p1x", int'(p1x_a), h1x);
      check("hold_p1y", int'(p1y_a), h1y);
      check("hold_p2x", int'(p2x_a), h2x);
      check("hold_p2y", int'(p2y_a), h2y);
      check("hold_score", int'(score_a), hsc);
      check("hold_passed", int'(passed_a), 0);
      $display("hold: 50 ticks paused, p1x=%0d p2x=%0d score=%03h", p1x_a, p2x_a, score_a);

      // restart on the tick the pulse is high
      for (int k = 0; k < 1000 && !mpass[0]; k++) tick(1'b0, 1'b0, 1'b1);
      check("pulse_seen", int'(passed_a), 1);
      tick(1'b0, 1'b1, 1'b1);
      check("restart_passed", int'(passed_a), 0);
      check("restart_score", int'(score_a), 'h000);
      check("restart_p1x", int'(p1x_a), 319);
      check("restart_p2x", int'(p2x_a), 639);
      check("restart_p1y", int'(p1y_a), 240);
      check("restart_p2y", int'(p2y_a), 240);
      $display("restart mid-pulse: passed=%0d score=%03h p1x=%0d p2x=%0d", passed_a, score_a, p1x_a, p2x_a);

      // BCD carries and saturation on the narrow playfield
      for (int k = 0; k < 20000 && msc[1] < 99; k++) tick(1'b0, 1'b0, 1'b1);
      check("bcd_099", int'(score_b), 'h099);
      $display("bcd: score=%03h", score_b);
`ifdef PIPE_SPEEDUP_EN
      xprev = int'(p1x_b);
      tick(1'b0, 1'b0, 1'b1);
      check("speed3_p1x", int'(p1x_b), (xprev < 3) ? 63 : xprev - 3);
      $display("speed: p1x %0d -> %0d", xprev, p1x_b);
`endif
      for (int k = 0; k < 20000 && msc[1] < 100; k++) tick(1'b0, 1'b0, 1'b1);
      check("bcd_100", int'(score_b), 'h100);
      check("bcd_100_passed", int'(passed_b), 1);
      $display("bcd: score=%03h passed=%0d", score_b, passed_b);
      for (int k = 0; k < 40000 && msc[1] < 999; k++) tick(1'b0, 1'b0, 1'b1);
      check("sat_999", int'(score_b), 'h999);
      $display("saturate: score=%03h", score_b);
      tick(1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 200 && !mpass[1]; k++) tick(1'b0, 1'b0, 1'b1);
      check("sat_pass_passed", int'(passed_b), 1);
      check("sat_pass_score", int'(score_b), 'h999);
      $display("saturate: extra pass passed=%0d score=%03h", passed_b, score_b);

      // randomised play: pauses, rare restarts/resets, moving birds
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 199) == 0) bird_a = 11'($urandom_range(0, 700));
         bird_b = 11'($urandom_range(0, 70));
         tick($urandom_range(0, 1999) == 0, $urandom_range(0, 399) == 0, $urandom_range(0, 9) != 0);
      end
      $display("random: 3000 ticks, scores A=%03h B=%03h", score_a, score_b);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
